// File: rtl/mem_pkg.sv
// Shared memory-side definitions: block geometry, arbiter state encoding and owner tags.
package mem_pkg;

  localparam int BLOCKSIZE      = 128;
  localparam int BYTE_ADDR_BITS = $clog2(BLOCKSIZE / 8);

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    RD_REQ,
    RD_WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  // Memory works on whole blocks, so the byte offset inside a block is dropped.
  function automatic logic [31:0] block_align(input logic [31:0] addr);
    return {addr[31:BYTE_ADDR_BITS], {BYTE_ADDR_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin chooser; the pointer moves past the requester just served.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_icache,
  input  logic   req_dcache,
  input  logic   advance,
  input  owner_t served,
  output logic   grant,
  output owner_t grant_owner
);

  owner_t ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= OWN_I;
    end else if (advance) begin
      ptr <= (served == OWN_I) ? OWN_D : OWN_I;
    end
  end

  always_comb begin
    grant       = req_icache | req_dcache;
    grant_owner = OWN_I;
    if (req_icache && req_dcache) begin
      grant_owner = ptr;
    end else if (req_dcache) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory block port between I-cache refills and D-cache misses,
// running a dirty D miss as an atomic write-back followed by its refill.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 IValid_i,
  input  logic [31:0]          IAddr_i,
  output logic                 IReady_o,
  output logic [BLOCKSIZE-1:0] IData_o,
  input  logic                 DValid_i,
  input  logic                 DDirty_i,
  input  logic [31:0]          DWAddr_i,
  input  logic [BLOCKSIZE-1:0] DWData_i,
  input  logic [31:0]          DRAddr_i,
  output logic                 DReady_o,
  output logic [BLOCKSIZE-1:0] DData_o,
  output logic                 MemValid_o,
  output logic                 MemWen_o,
  output logic [31:0]          MemAddr_o,
  output logic [BLOCKSIZE-1:0] MemWData_o,
  input  logic                 MemReady_i,
  input  logic [BLOCKSIZE-1:0] MemRData_i,
  output logic                 ErrTimeout_o
);

  localparam int            CW        = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  arb_state_t           state;
  arb_state_t           state_next;
  owner_t               owner;
  owner_t               grant_owner;
  logic                 grant;
  logic                 advance;
  logic                 timeout;
  logic [31:0]          wb_addr;
  logic [31:0]          rd_addr;
  logic [BLOCKSIZE-1:0] wb_data;
  logic [CW-1:0]        wait_cnt;

  rr_arbiter2 u_rr (
    .clk         (clk_i),
    .rst         (rst_i),
    .req_icache  (IValid_i),
    .req_dcache  (DValid_i),
    .advance     (advance),
    .served      (owner),
    .grant       (grant),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    timeout    = 1'b0;
    MemValid_o = 1'b0;
    MemWen_o   = 1'b0;
    MemAddr_o  = '0;
    MemWData_o = '0;
    IReady_o   = 1'b0;
    DReady_o   = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_next = (grant_owner == OWN_D && DDirty_i) ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        MemValid_o = 1'b1;
        MemWen_o   = 1'b1;
        MemAddr_o  = block_align(wb_addr);
        MemWData_o = wb_data;
        state_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (MemReady_i) begin
          state_next = RD_REQ;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout    = 1'b1;
          state_next = RESP;
        end
      end
      RD_REQ: begin
        MemValid_o = 1'b1;
        MemAddr_o  = block_align(rd_addr);
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (MemReady_i) begin
          state_next = RESP;
        end else if (wait_cnt == LAST_WAIT) begin
          timeout    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        IReady_o   = (owner == OWN_I);
        DReady_o   = (owner == OWN_D);
        advance    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A timed-out op still releases the requester, but with an all-zero block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner        <= OWN_I;
      wb_addr      <= '0;
      rd_addr      <= '0;
      wb_data      <= '0;
      wait_cnt     <= '0;
      ErrTimeout_o <= 1'b0;
      IData_o      <= '0;
      DData_o      <= '0;
    end else begin
      if (state == IDLE && grant) begin
        owner   <= grant_owner;
        rd_addr <= (grant_owner == OWN_I) ? IAddr_i : DRAddr_i;
        wb_addr <= DWAddr_i;
        wb_data <= DWData_i;
      end
      if (state == WB_REQ || state == RD_REQ) begin
        wait_cnt <= '0;
      end else if (state == WB_WAIT || state == RD_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        ErrTimeout_o <= 1'b1;
        if (owner == OWN_I) begin
          IData_o <= '0;
        end else begin
          DData_o <= '0;
        end
      end else if (state == RD_WAIT && MemReady_i) begin
        if (owner == OWN_I) begin
          IData_o <= MemRData_i;
        end else begin
          DData_o <= MemRData_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a block memory responder plus an expectation model of
// memory ops and Ready pulses, checked every cycle on the falling edge.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int          MAX_WAIT   = 8;
  localparam logic [31:0] ALIGN_MASK = ~32'(BLOCKSIZE / 8 - 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 IValid_i;
  logic [31:0]          IAddr_i;
  logic                 IReady_o;
  logic [BLOCKSIZE-1:0] IData_o;
  logic                 DValid_i;
  logic                 DDirty_i;
  logic [31:0]          DWAddr_i;
  logic [BLOCKSIZE-1:0] DWData_i;
  logic [31:0]          DRAddr_i;
  logic                 DReady_o;
  logic [BLOCKSIZE-1:0] DData_o;
  logic                 MemValid_o;
  logic                 MemWen_o;
  logic [31:0]          MemAddr_o;
  logic [BLOCKSIZE-1:0] MemWData_o;
  logic                 MemReady_i;
  logic [BLOCKSIZE-1:0] MemRData_i;
  logic                 ErrTimeout_o;
  logic                 mem_rdy;
  logic                 spur_rdy;

  assign MemReady_i = mem_rdy | spur_rdy;

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .IValid_i     (IValid_i),
    .IAddr_i      (IAddr_i),
    .IReady_o     (IReady_o),
    .IData_o      (IData_o),
    .DValid_i     (DValid_i),
    .DDirty_i     (DDirty_i),
    .DWAddr_i     (DWAddr_i),
    .DWData_i     (DWData_i),
    .DRAddr_i     (DRAddr_i),
    .DReady_o     (DReady_o),
    .DData_o      (DData_o),
    .MemValid_o   (MemValid_o),
    .MemWen_o     (MemWen_o),
    .MemAddr_o    (MemAddr_o),
    .MemWData_o   (MemWData_o),
    .MemReady_i   (MemReady_i),
    .MemRData_i   (MemRData_i),
    .ErrTimeout_o (ErrTimeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                   wen;
    logic [31:0]          addr;
    logic [BLOCKSIZE-1:0] data;
  } op_t;

  typedef struct {
    bit                   is_d;
    logic [BLOCKSIZE-1:0] data;
    bit                   tmo;
  } rsp_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  op_t                  exp_ops[$];
  rsp_t                 exp_rsp[$];
  logic [BLOCKSIZE-1:0] model_mem [logic [31:0]];
  logic [BLOCKSIZE-1:0] mem_store [logic [31:0]];
  logic [BLOCKSIZE-1:0] last_i;
  logic [BLOCKSIZE-1:0] last_d;
  bit                   exp_err;
  int                   i_pulses = 0;
  int                   d_pulses = 0;
  int                   strobe_cyc = -1;
  int                   err_cyc = -1;
  int                   mem_lat = 1;
  bit                   mem_silent = 1'b0;
  op_t                  cmp_op;
  rsp_t                 cmp_rsp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory contents before anything is written: distinct per block address.
  function automatic logic [BLOCKSIZE-1:0] pattern(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5a5a_5a5a, 32'h600d_0000 | {16'h0, a[15:0]}};
  endfunction

  function automatic logic [BLOCKSIZE-1:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : pattern(a);
  endfunction

  function automatic logic [BLOCKSIZE-1:0] mem_read(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : pattern(a);
  endfunction

  task automatic expect_i(input logic [31:0] addr, input bit tmo);
    logic [31:0] a;
    a = addr & ALIGN_MASK;
    exp_ops.push_back('{wen: 1'b0, addr: a, data: '0});
    exp_rsp.push_back('{is_d: 1'b0, data: tmo ? '0 : model_read(a), tmo: tmo});
  endtask

  task automatic expect_d(input bit dirty, input logic [31:0] waddr,
                          input logic [BLOCKSIZE-1:0] wdata, input logic [31:0] raddr);
    logic [31:0] wa;
    logic [31:0] ra;
    wa = waddr & ALIGN_MASK;
    ra = raddr & ALIGN_MASK;
    if (dirty) begin
      exp_ops.push_back('{wen: 1'b1, addr: wa, data: wdata});
      model_mem[wa] = wdata;
    end
    exp_ops.push_back('{wen: 1'b0, addr: ra, data: '0});
    exp_rsp.push_back('{is_d: 1'b1, data: model_read(ra), tmo: 1'b0});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_ops.delete();
    exp_rsp.delete();
    exp_err = 1'b0;
    last_i  = '0;
    last_d  = '0;
    err_cyc = -1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called just after a rising edge; Valid drops in the cycle following the Ready pulse.
  task automatic req_i(input logic [31:0] addr, input bit scramble, output int gcyc, output int rcyc);
    IAddr_i  = addr;
    IValid_i = 1'b1;
    gcyc     = cyc;
    rcyc     = -1;
    @(posedge clk);
    #1;
    if (scramble) IAddr_i = ~addr;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (IReady_o) begin
        rcyc = cyc;
        break;
      end
    end
    if (rcyc < 0) check_output("iready_seen", 128'(IReady_o), 128'd1);
    @(posedge clk);
    #1 IValid_i = 1'b0;
  endtask

  task automatic req_d(input bit dirty, input logic [31:0] waddr, input logic [BLOCKSIZE-1:0] wdata,
                       input logic [31:0] raddr, input bit scramble, output int gcyc, output int rcyc);
    DDirty_i = dirty;
    DWAddr_i = waddr;
    DWData_i = wdata;
    DRAddr_i = raddr;
    DValid_i = 1'b1;
    gcyc     = cyc;
    rcyc     = -1;
    @(posedge clk);
    #1;
    if (scramble) begin
      DDirty_i = ~dirty;
      DWAddr_i = ~waddr;
      DWData_i = ~wdata;
      DRAddr_i = ~raddr;
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (DReady_o) begin
        rcyc = cyc;
        break;
      end
    end
    if (rcyc < 0) check_output("dready_seen", 128'(DReady_o), 128'd1);
    @(posedge clk);
    #1 DValid_i = 1'b0;
  endtask

  // Block memory: answers each strobe mem_lat cycles later, forgets pending work on reset.
  initial begin : responder
    bit                   r_wen;
    logic [31:0]          r_addr;
    logic [BLOCKSIZE-1:0] r_data;
    bit                   aborted;
    mem_rdy    = 1'b0;
    MemRData_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && MemValid_o && !mem_silent) begin
        r_wen   = MemWen_o;
        r_addr  = MemAddr_o;
        r_data  = MemWData_o;
        aborted = 1'b0;
        for (int k = 0; k < mem_lat; k++) begin
          @(posedge clk);
          if (rst) aborted = 1'b1;
        end
        #1;
        if (!aborted && !rst) begin
          if (r_wen) mem_store[r_addr] = r_data;
          MemRData_i = r_wen ? '0 : mem_read(r_addr);
          mem_rdy    = 1'b1;
          @(posedge clk);
          #1 mem_rdy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (MemValid_o) begin
        strobe_cyc = cyc;
        check_output("memop_due", 128'(exp_ops.size() != 0), 128'd1);
        if (exp_ops.size() != 0) begin
          cmp_op = exp_ops.pop_front();
          check_output("memop_wen", 128'(MemWen_o), 128'(cmp_op.wen));
          check_output("memop_addr", 128'(MemAddr_o), 128'(cmp_op.addr));
          if (cmp_op.wen) check_output("memop_wdata", MemWData_o, cmp_op.data);
        end
      end
      check_output("ready_exclusive", 128'(IReady_o & DReady_o), 128'd0);
      if (IReady_o ^ DReady_o) begin
        check_output("resp_due", 128'(exp_rsp.size() != 0), 128'd1);
        if (exp_rsp.size() != 0) begin
          cmp_rsp = exp_rsp.pop_front();
          check_output("resp_owner", 128'(DReady_o), 128'(cmp_rsp.is_d));
          if (DReady_o) begin
            check_output("ddata", DData_o, cmp_rsp.data);
            last_d = cmp_rsp.data;
            d_pulses++;
          end else begin
            check_output("idata", IData_o, cmp_rsp.data);
            last_i = cmp_rsp.data;
            i_pulses++;
          end
          if (cmp_rsp.tmo) exp_err = 1'b1;
        end
      end
      if (!IReady_o) check_output("idata_hold", IData_o, last_i);
      if (!DReady_o) check_output("ddata_hold", DData_o, last_d);
      check_output("err_flag", 128'(ErrTimeout_o), 128'(exp_err));
      if (ErrTimeout_o && err_cyc < 0) err_cyc = cyc;
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int gi, ri, gd, rd, pi, pd;
    IValid_i = 1'b0;
    IAddr_i  = '0;
    DValid_i = 1'b0;
    DDirty_i = 1'b0;
    DWAddr_i = '0;
    DWData_i = '0;
    DRAddr_i = '0;
    spur_rdy = 1'b0;
    apply_reset();

    check_output("rst_memvalid", 128'(MemValid_o), 128'd0);
    check_output("rst_iready", 128'(IReady_o), 128'd0);
    check_output("rst_dready", 128'(DReady_o), 128'd0);
    check_output("rst_err", 128'(ErrTimeout_o), 128'd0);
    check_output("rst_idata", IData_o, 128'd0);

    // I-cache refill alone: Ready in the fourth cycle counting the grant cycle.
    expect_i(32'hbfc0_0010, 1'b0);
    req_i(32'hbfc0_0010, 1'b1, gi, ri);
    check_output("t1_latency", 128'(ri - gi), 128'd3);
    check_output("t1_idata_lit", IData_o, 128'hbfc00010_403fffef_e59a5a4a_600d0010);

    // Dirty D miss: write-back then refill, Ready in the sixth cycle.
    expect_d(1'b1, 32'h0001_0020, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 32'h0001_0040);
    req_d(1'b1, 32'h0001_0020, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
          32'h0001_0040, 1'b1, gd, rd);
    check_output("t2_latency", 128'(rd - gd), 128'd5);
    check_output("t2_ddata_lit", DData_o, 128'h00010040_fffeffbf_5a5b5a1a_600d0040);

    // Simultaneous requests straight after reset: I first, D granted once I drops Valid.
    @(posedge clk);
    apply_reset();
    expect_i(32'h0000_3000, 1'b0);
    expect_d(1'b0, 32'h0000_0000, '0, 32'h0000_5010);
    pi = i_pulses;
    pd = d_pulses;
    fork
      req_i(32'h0000_3000, 1'b0, gi, ri);
      req_d(1'b0, 32'h0000_0000, '0, 32'h0000_5010, 1'b0, gd, rd);
    join
    check_output("t3_i_latency", 128'(ri - gi), 128'd3);
    check_output("t3_d_after_i", 128'(rd - ri), 128'd4);
    check_output("t3_i_pulses", 128'(i_pulses - pi), 128'd1);
    check_output("t3_d_pulses", 128'(d_pulses - pd), 128'd1);

    // Silent memory: error rises eight edges after the edge that samples the strobe,
    // together with a zero-data Ready pulse; the unaligned address goes out block-aligned.
    mem_silent = 1'b1;
    expect_i(32'h0000_1237, 1'b1);
    req_i(32'h0000_1237, 1'b0, gi, ri);
    check_output("t4_err_delay", 128'(err_cyc - strobe_cyc), 128'd9);
    check_output("t4_ready_with_err", 128'(ri - err_cyc), 128'd0);
    check_output("t4_total_latency", 128'(ri - gi), 128'd10);
    check_output("t4_idata_zero", IData_o, 128'd0);
    mem_silent = 1'b0;

    // Reset in the middle of a write-back: everything drops at once, nothing replays.
    mem_lat = 6;
    @(posedge clk);
    #1;
    exp_ops.push_back('{wen: 1'b1, addr: 32'h0002_0000, data: 128'hcafe});
    DDirty_i = 1'b1;
    DWAddr_i = 32'h0002_0000;
    DWData_i = 128'hcafe;
    DRAddr_i = 32'h0002_0100;
    DValid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("t5_wb_issued", 128'(exp_ops.size()), 128'd0);
    rst = 1'b1;
    #1;
    check_output("t5_memvalid", 128'(MemValid_o), 128'd0);
    check_output("t5_memaddr", 128'(MemAddr_o), 128'd0);
    check_output("t5_dready", 128'(DReady_o), 128'd0);
    check_output("t5_ddata", DData_o, 128'd0);
    check_output("t5_err_cleared", 128'(ErrTimeout_o), 128'd0);
    DValid_i = 1'b0;
    DDirty_i = 1'b0;
    apply_reset();
    mem_lat = 1;
    expect_i(32'h0040_0020, 1'b0);
    req_i(32'h0040_0020, 1'b0, gi, ri);
    check_output("t5_restart_latency", 128'(ri - gi), 128'd3);

    // Spurious MemReady while idle must not produce any op or Ready.
    pi = i_pulses + d_pulses;
    @(posedge clk);
    #1 spur_rdy = 1'b1;
    @(posedge clk);
    #1 spur_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_output("t6_no_pulse", 128'(i_pulses + d_pulses), 128'(pi));
    @(posedge clk);
    #1;
    expect_d(1'b0, 32'hffff_fff0, '1, 32'h0000_7000);
    req_d(1'b0, 32'hffff_fff0, '1, 32'h0000_7000, 1'b0, gd, rd);
    check_output("t6_latency", 128'(rd - gd), 128'd3);

    repeat (2) @(posedge clk);
    check_output("ops_drained", 128'(exp_ops.size()), 128'd0);
    check_output("rsp_drained", 128'(exp_rsp.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
